// File: rtl/mdu_ctrl.sv
// mdu_ctrl: E-stage issue, stall and HI/LO read controller for the multiply/divide unit,
// with an independent BUSY timing monitor that flags a misbehaving MDU.
module mdu_ctrl #(
  parameter int MUL_CYC = 5,
  parameter int DIV_CYC = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        e_valid,
  input  logic [3:0]  e_op,
  input  logic [31:0] e_rs,
  input  logic [31:0] e_rt,
  input  logic        flush,
  input  logic        mdu_busy,
  input  logic [31:0] mdu_hi,
  input  logic [31:0] mdu_lo,
  output logic        mdu_start,
  output logic [3:0]  mdu_op,
  output logic [31:0] mdu_d1,
  output logic [31:0] mdu_d2,
  output logic        stall,
  output logic [31:0] rdata,
  output logic        rdata_valid,
  output logic        div_zero,
  output logic        proto_err
);
  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] LAUNCH = 2'd1;
  localparam logic [1:0] WAIT   = 2'd2;
  localparam int CMAX = (MUL_CYC > DIV_CYC) ? MUL_CYC : DIV_CYC;
  localparam int CW   = ($clog2(CMAX + 1) < 4) ? 4 : $clog2(CMAX + 1);
  logic [1:0]    r_state;
  logic [CW-1:0] r_cnt;
  logic          r_start;
  logic [3:0]    r_op;
  logic [31:0]   r_d1;
  logic [31:0]   r_d2;
  logic          r_perr;
  logic          w_cls;
  logic          w_arith;
  logic          w_move;
  logic          w_read;
  logic          w_accept;
  logic          w_serve;
  logic          w_l_arith;
  logic          w_l_div;
  logic [1:0]    w_next;
  logic [CW-1:0] w_cnt_next;
  always_comb begin
    w_arith    = (e_op >= 4'd1) && (e_op <= 4'd5);
    w_move     = (e_op == 4'd6) || (e_op == 4'd7);
    w_read     = (e_op == 4'd8) || (e_op == 4'd9);
    w_cls      = e_valid && !flush && (w_arith || w_move || w_read);
    w_accept   = w_cls && (w_arith || w_move) && (r_state == IDLE);
    w_serve    = reset && w_cls && w_read && (r_state == IDLE);
    // operand registers are zero outside LAUNCH, so r_op alone identifies the launched op
    w_l_arith  = (r_state == LAUNCH) && (r_op >= 4'd1) && (r_op <= 4'd5);
    w_l_div    = (r_state == LAUNCH) && ((r_op == 4'd3) || (r_op == 4'd4));
    w_next     = (r_state == IDLE)   ? (w_accept ? LAUNCH : IDLE) :
                 (r_state == LAUNCH) ? (w_l_arith ? WAIT : IDLE) :
                 ((r_state == WAIT) && (r_cnt != CW'(1))) ? WAIT : IDLE;
    w_cnt_next = w_l_arith ? (w_l_div ? CW'(DIV_CYC) : CW'(MUL_CYC)) :
                 (r_state == WAIT) ? r_cnt - CW'(1) : '0;
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_start <= 1'b0;
      r_op    <= '0;
      r_d1    <= '0;
      r_d2    <= '0;
      r_perr  <= 1'b0;
    end else begin
      r_state <= w_next;
      r_cnt   <= w_cnt_next;
      r_start <= w_accept && w_arith;
      r_op    <= w_accept ? e_op : '0;
      r_d1    <= w_accept ? e_rs : '0;
      r_d2    <= w_accept ? e_rt : '0;
      r_perr  <= r_perr || ((r_state == WAIT) ? !mdu_busy : mdu_busy);
    end
  end
  assign mdu_start   = r_start;
  assign mdu_op      = r_op;
  assign mdu_d1      = r_d1;
  assign mdu_d2      = r_d2;
  assign stall       = reset && w_cls && (r_state != IDLE);
  assign rdata_valid = w_serve;
  assign rdata       = w_serve ? ((e_op == 4'd8) ? mdu_hi : mdu_lo) : '0;
  assign div_zero    = reset && w_l_div && (r_d2 == '0);
  assign proto_err   = r_perr;
endmodule

// File: tb/tb_mdu_ctrl.sv
// tb_mdu_ctrl: directed bench for mdu_ctrl with a behavioural MDU and a read-result scoreboard.
module tb_mdu_ctrl;
  logic        clk = 1'b0;
  logic        reset;
  logic        e_valid;
  logic [3:0]  e_op;
  logic [31:0] e_rs;
  logic [31:0] e_rt;
  logic        flush;
  logic        mdu_busy;
  logic [31:0] mdu_hi;
  logic [31:0] mdu_lo;
  logic        mdu_start;
  logic [3:0]  mdu_op;
  logic [31:0] mdu_d1;
  logic [31:0] mdu_d2;
  logic        stall;
  logic [31:0] rdata;
  logic        rdata_valid;
  logic        div_zero;
  logic        proto_err;
  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];
  int bcnt;
  logic kill;
  logic [31:0] p_hi, p_lo;
  int n_start = 0, n_dz = 0, n_dzl = 0;
  logic [31:0] s_d1, s_d2;
  logic [3:0] s_op;
  mdu_ctrl #(.MUL_CYC(5), .DIV_CYC(10)) dut (
    .clk(clk), .reset(reset), .e_valid(e_valid), .e_op(e_op), .e_rs(e_rs), .e_rt(e_rt),
    .flush(flush), .mdu_busy(mdu_busy), .mdu_hi(mdu_hi), .mdu_lo(mdu_lo),
    .mdu_start(mdu_start), .mdu_op(mdu_op), .mdu_d1(mdu_d1), .mdu_d2(mdu_d2),
    .stall(stall), .rdata(rdata), .rdata_valid(rdata_valid), .div_zero(div_zero),
    .proto_err(proto_err)
  );
  always #5 clk = ~clk;
  function automatic logic [63:0] mdu_res(input logic [3:0] op, input logic [31:0] a, b, input logic [63:0] acc);
    logic [63:0] r;
    r = '0;
    if (op == 4'd1) r = longint'($signed(a)) * longint'($signed(b));
    if (op == 4'd2) r = {32'd0, a} * {32'd0, b};
    if (op == 4'd5) r = acc + longint'($signed(a)) * longint'($signed(b));
    if (op == 4'd3 && b != 0) r = {$signed(a) % $signed(b), $signed(a) / $signed(b)};
    if (op == 4'd4 && b != 0) r = {a % b, a / b};
    return r;
  endfunction
  // behavioural MDU: samples start/op at the end of LAUNCH, BUSY for N cycles, then HI/LO update
  always @(posedge clk) begin
    if (!reset) begin
      bcnt <= 0; mdu_hi <= '0; mdu_lo <= '0;
    end else begin
      if (bcnt > 0) begin
        bcnt <= bcnt - 1;
        if (bcnt == 1) begin mdu_hi <= p_hi; mdu_lo <= p_lo; end
      end
      if (mdu_start) begin
        bcnt <= (mdu_op == 4'd3 || mdu_op == 4'd4) ? 10 : 5;
        {p_hi, p_lo} <= mdu_res(mdu_op, mdu_d1, mdu_d2, {mdu_hi, mdu_lo});
      end else if (mdu_op == 4'd6) mdu_hi <= mdu_d1;
      else if (mdu_op == 4'd7) mdu_lo <= mdu_d1;
    end
  end
  assign mdu_busy = (bcnt != 0) && !kill;
  always @(negedge clk) begin
    if (mdu_start) begin n_start++; s_d1 = mdu_d1; s_d2 = mdu_d2; s_op = mdu_op; end
    if (div_zero) begin n_dz++; if (mdu_start) n_dzl++; end
  end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic do_op(input logic [3:0] op, input logic [31:0] rs, input logic [31:0] rt, output int stalls);
    logic [31:0] ex;
    stalls = 0;
    e_valid = 1'b1; e_op = op; e_rs = rs; e_rt = rt;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (!stall) break;
      stalls++;
    end
    if (stalls >= 60) chk("stall_bound", 32'(stalls), 32'd0);
    if (op >= 4'd8) begin
      ex = exp_q.pop_front();
      chk("rdata_valid", {31'd0, rdata_valid}, 32'd1);
      chk("rdata", rdata, ex);
    end
    @(posedge clk); #1;
    e_valid = 1'b0; e_op = '0;
  endtask
  initial begin
    int st, nd, ndl, ns;
    reset = 1'b0; e_valid = 1'b0; e_op = '0; e_rs = '0; e_rt = '0; flush = 1'b0; kill = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    @(negedge clk);
    chk("rst_start", {31'd0, mdu_start}, 32'd0);
    chk("rst_d1", mdu_d1, 32'd0);
    chk("rst_stall", {31'd0, stall}, 32'd0);
    chk("rst_perr", {31'd0, proto_err}, 32'd0);
    @(posedge clk); #1;
    do_op(4'd1, 32'd7, 32'hFFFFFFFD, st);
    chk("mult_acc_stall", 32'(st), 32'd0);
    exp_q.push_back(32'hFFFFFFFF);
    do_op(4'd8, 32'd0, 32'd0, st);
    chk("mult_mfhi_stall", 32'(st), 32'd6);
    chk("mult_nstart", 32'(n_start), 32'd1);
    chk("mult_d1", s_d1, 32'd7);
    chk("mult_d2", s_d2, 32'hFFFFFFFD);
    chk("mult_op", {28'd0, s_op}, 32'd1);
    exp_q.push_back(32'hFFFFFFEB);
    do_op(4'd9, 32'd0, 32'd0, st);
    chk("mult_mflo_stall", 32'(st), 32'd0);
    do_op(4'd4, 32'd100, 32'd7, st);
    exp_q.push_back(32'd14);
    do_op(4'd9, 32'd0, 32'd0, st);
    chk("divu_stall", 32'(st), 32'd11);
    exp_q.push_back(32'd2);
    do_op(4'd8, 32'd0, 32'd0, st);
    chk("divu_mfhi_stall", 32'(st), 32'd0);
    chk("divu_perr", {31'd0, proto_err}, 32'd0);
    do_op(4'd7, 32'h1234, 32'd0, st);
    exp_q.push_back(32'h1234);
    do_op(4'd9, 32'd0, 32'd0, st);
    chk("mtlo_stall", 32'(st), 32'd1);
    nd = n_dz; ndl = n_dzl;
    do_op(4'd3, 32'd50, 32'd0, st);
    e_valid = 1'b1; e_op = 4'd0;
    @(negedge clk);
    chk("nonmdu_stall", {31'd0, stall}, 32'd0);
    @(posedge clk); #1;
    e_op = 4'd8; flush = 1'b1;
    @(negedge clk);
    chk("flush_rd_stall", {31'd0, stall}, 32'd0);
    chk("flush_rd_valid", {31'd0, rdata_valid}, 32'd0);
    @(posedge clk); #1;
    flush = 1'b0;
    exp_q.push_back(32'd0);
    do_op(4'd8, 32'd0, 32'd0, st);
    chk("divz_stall", 32'(st), 32'd9);
    chk("divz_pulse", 32'(n_dz - nd), 32'd1);
    chk("divz_launch", 32'(n_dzl - ndl), 32'd1);
    do_op(4'd1, 32'd2, 32'd3, st);
    do_op(4'd5, 32'd4, 32'd5, st);
    chk("madd_stall", 32'(st), 32'd6);
    exp_q.push_back(32'd26);
    do_op(4'd9, 32'd0, 32'd0, st);
    chk("madd_rd_stall", 32'(st), 32'd6);
    do_op(4'd1, 32'd3, 32'd4, st);
    repeat (3) begin @(posedge clk); #1; end
    reset = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    @(negedge clk);
    chk("rstw_start", {31'd0, mdu_start}, 32'd0);
    chk("rstw_op", {28'd0, mdu_op}, 32'd0);
    chk("rstw_d2", mdu_d2, 32'd0);
    chk("rstw_rvalid", {31'd0, rdata_valid}, 32'd0);
    chk("rstw_perr", {31'd0, proto_err}, 32'd0);
    @(posedge clk); #1;
    exp_q.push_back(32'd0);
    do_op(4'd9, 32'd0, 32'd0, st);
    chk("rstw_mflo_stall", 32'(st), 32'd0);
    do_op(4'd1, 32'd2, 32'd3, st);
    @(posedge clk); #1;
    @(posedge clk); #1;
    kill = 1'b1;
    @(negedge clk);
    chk("fault_pre", {31'd0, proto_err}, 32'd0);
    @(posedge clk); #1;
    kill = 1'b0;
    @(negedge clk);
    chk("fault_set", {31'd0, proto_err}, 32'd1);
    repeat (10) @(posedge clk);
    @(negedge clk);
    chk("fault_hold", {31'd0, proto_err}, 32'd1);
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    @(negedge clk);
    chk("fault_clr", {31'd0, proto_err}, 32'd0);
    @(posedge clk); #1;
    ns = n_start;
    e_valid = 1'b1; e_op = 4'd1; e_rs = 32'd5; e_rt = 32'd6; flush = 1'b1;
    @(negedge clk);
    chk("flush_stall", {31'd0, stall}, 32'd0);
    @(posedge clk); #1;
    e_valid = 1'b0; e_op = '0; flush = 1'b0;
    @(negedge clk);
    chk("flush_start", {31'd0, mdu_start}, 32'd0);
    chk("flush_nstart", 32'(n_start), 32'(ns));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/mdu_ctrl.md
# mdu_ctrl

Pipeline-side initiator for the multiply/divide unit. It sits in the E stage between the decoded instruction stream and the MDU's start/operand/BUSY/HI/LO port, and it owns the whole issue handshake. It launches MULT/MULTU/DIV/DIVU/MADD and MTHI/MTLO into the MDU and stalls the front pipeline while an MDU-class instruction conflicts. It serves MFHI/MFLO reads and independently times each operation to detect a misbehaving MDU.

## Interface
Parameters:
- MUL_CYC, 5, cycles MDU BUSY stays high for MULT/MULTU/MADD
- DIV_CYC, 10, cycles MDU BUSY stays high for DIV/DIVU

Ports:
- clk  in  1  clock; all state on rising edge
- reset  in  1  synchronous, active-low (0 = reset)
- e_valid  in  1  E-stage instruction valid
- e_op  in  4  0 NONE, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MADD, 6 MTHI, 7 MTLO, 8 MFHI, 9 MFLO, others = NONE
- e_rs  in  32  forwarded rs value
- e_rt  in  32  forwarded rt value
- flush  in  1  kill the E-stage instruction this cycle
- mdu_busy  in  1  MDU BUSY
- mdu_hi  in  32  MDU HI
- mdu_lo  in  32  MDU LO
- mdu_start  out  1  MDU start (registered)
- mdu_op  out  4  operation to MDU, e_op encoding (registered; top level maps it to the MDU select)
- mdu_d1  out  32  operand 1 (registered)
- mdu_d2  out  32  operand 2 (registered)
- stall  out  1  freeze F/D/E this cycle
- rdata  out  32  MFHI/MFLO result
- rdata_valid  out  1  rdata valid for the E instruction
- div_zero  out  1  pulse: DIV/DIVU issued with divisor 0
- proto_err  out  1  sticky: MDU BUSY disagreed with expected timing

## Operation
- Definitions:
  - cls = e_valid & !flush & e_op in 1..9.
  - Arith ops: 1–5.
  - Move ops: 6–7.
  - Read ops: 8–9.
- FSM states are IDLE, LAUNCH and WAIT. There is a down-counter cnt (4 bits minimum).
- Registered outputs (mdu_start, mdu_op, mdu_d1, mdu_d2) are nonzero only in LAUNCH. In IDLE and WAIT they are 0.
- IDLE:
  - Arith or move op with cls: accept.
    - Capture op into mdu_op, e_rs into mdu_d1, e_rt into mdu_d2.
    - mdu_start = 1 for arith, 0 for move.
    - Go to LAUNCH. stall = 0, since the instruction leaves E.
  - Read op: rdata = mdu_hi (op 8) or mdu_lo (op 9), combinational. rdata_valid = 1, stall = 0.
- LAUNCH (exactly 1 cycle). The MDU samples start/op/operands at the end of this cycle.
  - Arith: cnt <= MUL_CYC for ops 1, 2, 5 and DIV_CYC for ops 3, 4; go to WAIT.
  - Move: go to IDLE.
  - div_zero = 1 this cycle iff op is 3 or 4 and mdu_d2 == 0. The op is still issued.
- WAIT: cnt decrements each cycle. When cnt reaches 0 (on the edge where cnt == 1), go to IDLE.
- stall = 1 in LAUNCH or WAIT when cls is true (any MDU-class op, reads included). Otherwise stall = 0.
- rdata_valid = 0 and rdata = 0 whenever not serving a read in IDLE.
- proto_err is set, and held until reset, when either:
  - mdu_busy == 0 in any WAIT cycle, or
  - mdu_busy == 1 in any IDLE or LAUNCH cycle.
- Flush handling:
  - flush blocks acceptance and forces stall = 0.
  - An op already in LAUNCH or WAIT is never cancelled by flush.
- A non-MDU instruction (cls false) never stalls, in any state.

## Timing
- Reset (reset == 0 at an edge):
  - State goes to IDLE; cnt, mdu_start, mdu_op, mdu_d1, mdu_d2, div_zero, proto_err all become 0.
  - stall, rdata and rdata_valid are 0 while in reset.
  - Reset mid-LAUNCH or mid-WAIT abandons the op. The MDU is reset on the same edge by the inverted signal.
- Arith accepted at edge t:
  - mdu_start is high in cycle t+1.
  - The MDU raises BUSY after edge t+1.
  - WAIT lasts N cycles (N = MUL_CYC or DIV_CYC); IDLE resumes after edge t+1+N.
  - HI/LO are valid from that same edge.
  - Back-to-back MDU ops: the earliest next accept is edge t+1+N.
- Move accepted at edge t: HI/LO are written at edge t+1. A read in E during cycle t+1 stalls and gets the new value in cycle t+2.
- Read with no op in flight: zero-latency, same cycle.

## Test plan
- MULT, e_rs = 7, e_rt = -3:
  - mdu_start high for 1 cycle with d1 = 7, d2 = 0xFFFFFFFD.
  - MFHI issued the next cycle stalls for exactly 6 cycles (the LAUNCH cycle plus 5 WAIT cycles).
  - MFHI/MFLO then return 0xFFFFFFFF / 0xFFFFFFEB.
- DIVU, 100 / 7, immediately followed by MFLO then MFHI:
  - stall for 11 cycles (LAUNCH plus 10 WAIT cycles).
  - rdata 14, then 2; proto_err stays 0.
- MTLO 0x1234 then MFLO back-to-back: MFLO stalls 1 cycle, then rdata = 0x1234 with rdata_valid = 1.
- DIV with e_rt = 0: div_zero pulses 1 cycle in LAUNCH, then a normal 10-cycle WAIT.
- MULT accepted, reset driven to 0 during the 3rd WAIT cycle: the next cycle is IDLE with all outputs 0, and a following MFLO does not stall.
- Fault injection:
  - Force mdu_busy = 0 in the 2nd WAIT cycle → proto_err goes to 1 and stays 1 until reset.
  - MULT presented with flush = 1 → no mdu_start and no stall.
